bram_arbiter: RTL
=================

Name: bram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one byte-enabled single-port block RAM (combinational read, synchronous byte-column write).
- Port 0 is read-only (instruction fetch); port 1 is read/write with per-column byte enables (data access).
- Arbitration is round-robin with a registered response stage.
- Sits between the core's fetch/load-store units and the RAM instance in the top level.

Parameters:
- AddressBitWidth, 16, word address width of the RAM.
- DataBitWidth, 32, word width.
- ColumnBitWidth, 8, byte-enable column width; ColumnCount = DataBitWidth/ColumnBitWidth (derived localparam).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- p0_req  input  1  port 0 read request, held until accepted.
- p0_addr  input  AddressBitWidth  port 0 word address.
- p0_ready  output  1  port 0 request accepted this cycle (combinational).
- p0_rvalid  output  1  port 0 read data valid (registered).
- p0_rdata  output  DataBitWidth  port 0 read data (registered).
- p1_req  input  1  port 1 request, held until accepted.
- p1_we  input  ColumnCount  port 1 per-column write enable; zero means read.
- p1_addr  input  AddressBitWidth  port 1 word address.
- p1_wdata  input  DataBitWidth  port 1 write data.
- p1_ready  output  1  port 1 request accepted this cycle.
- p1_rvalid  output  1  port 1 response valid (registered).
- p1_rdata  output  DataBitWidth  port 1 old word at the address (registered).
- busy  output  1  arbiter not accepting requests.
- ram_we  output  ColumnCount  RAM column write enables.
- ram_addr  output  AddressBitWidth  RAM address.
- ram_din  output  DataBitWidth  RAM write data.
- ram_dout  input  DataBitWidth  RAM combinational read data.

Behaviour:
- Reset: all outputs 0; rvalid/rdata registers 0; last_grant = 1 (port 0 wins first contention); state = RUN (INIT with the optional feature).
- Arbitration in RUN, combinational each cycle:
  - only p0_req asserted: grant 0.
  - only p1_req asserted: grant 1.
  - both asserted: grant the port not equal to last_grant.
  - neither asserted: ram_we = 0, ram_addr = 0, ram_din = 0.
- Grant:
  - pX_ready = 1.
  - ram_addr = pX_addr.
  - ram_we = p1_we for port 1, 0 for port 0.
  - ram_din = p1_wdata for port 1, 0 for port 0.
  - last_grant updates to X at the clock edge.
- Response latency is exactly 1 cycle:
  - At the accepting edge, pX_rdata <= ram_dout and pX_rvalid <= 1.
  - A non-granted port's rvalid <= 0; its rdata holds its last value.
- Writes: the RAM updates at the same edge. Response is read-before-write, so p1_rdata returns the pre-write word. rvalid acts as the write acknowledge.
- Throughput: one access per cycle total. Under continuous contention, grants strictly alternate 0,1,0,1.
- Requester rules: pX_addr, p1_we and p1_wdata are stable while pX_req is high and not ready. A requester may drop req without being accepted; nothing is issued.
- Back-to-back: a port may be re-granted the cycle after its acceptance if the other port is idle.
- busy = 1 only in INIT; in RUN busy = 0.
- Reset mid-operation: in-flight rvalid is cleared asynchronously and the response is lost. A write accepted at the reset edge is not guaranteed to complete.
- Address wrap: none; the full 2**AddressBitWidth range is valid.

Optional Feature:
- Macro BRAM_ARB_CLEAR_EN.
- With the macro:
  - After reset release, state = INIT with busy = 1 and both ready = 0.
  - A counter walks addresses 0 .. 2**AddressBitWidth-1, one per cycle: ram_we = all ones, ram_din = 0.
  - After the last address, next cycle state = RUN, busy = 0.
  - INIT lasts exactly 2**AddressBitWidth cycles.
- Without the macro: no INIT state or counter; RUN immediately after reset; RAM content is not cleared by this block.

Decomposition:
- Package bram_arb_pkg holds:
  - enum state_e {StateInit, StateRun}.
  - grant index constants GrantP0 = 0, GrantP1 = 1.
- The RAM itself is not instantiated here; the top level connects ram_* to the bram instance.
- One natural sub-module: bram_arb_rr, the 2-way round-robin grant logic (req[1:0], last_grant -> grant[1:0]).

Test Plan:
- Clear: with BRAM_ARB_CLEAR_EN, AddressBitWidth = 4, release reset -> busy high 16 cycles, ram_we = 4'b1111 with addr 0..15, then busy = 0. Subsequent p0 read of addr 5 returns 0.
- Write/read: p1 write addr 3, we = 4'b0101, wdata = 32'hAABBCCDD over a word of 32'h11223344 -> p1_rdata = 32'h11223344 next cycle. p0 read addr 3 then returns 32'h11BB33DD.
- Contention: p0_req and p1_req held 6 cycles after reset -> grant order 0,1,0,1,0,1; each rvalid pulses the cycle after its ready.
- Idle gaps: p1 alone 3 consecutive cycles -> p1_ready = 1 each cycle, p1_rvalid high cycles 2-4, p0_rvalid stays 0.
- Async reset: assert rst mid-cycle while p0_rvalid = 1 -> p0_rvalid and p0_rdata go 0 immediately without a clock edge; first contention after release grants port 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
// Optional power-on RAM clear is selected with BRAM_ARB_CLEAR_EN.
package bram_arb_pkg;

  typedef enum logic {
    StateInit = 1'b0,
    StateRun  = 1'b1
  } state_e;

  localparam logic GrantP0 = 1'b0;
  localparam logic GrantP1 = 1'b1;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin grant: under contention the port that did not win last time wins.
// Purely combinational; grant is one-hot or zero.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | (last_grant == GrantP1));
    grant[1] = req[1] & (~req[0] | (last_grant == GrantP0));
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter for one single-port byte-enabled RAM: port 0 read-only, port 1 read/write.
// Responses are registered one cycle after acceptance; BRAM_ARB_CLEAR_EN adds a zero-fill INIT phase.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int AddressBitWidth = 16,
  parameter  int DataBitWidth    = 32,
  parameter  int ColumnBitWidth  = 8,
  localparam int ColumnCount     = DataBitWidth / ColumnBitWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p0_req,
  input  logic [AddressBitWidth-1:0] p0_addr,
  output logic                       p0_ready,
  output logic                       p0_rvalid,
  output logic [DataBitWidth-1:0]    p0_rdata,
  input  logic                       p1_req,
  input  logic [ColumnCount-1:0]     p1_we,
  input  logic [AddressBitWidth-1:0] p1_addr,
  input  logic [DataBitWidth-1:0]    p1_wdata,
  output logic                       p1_ready,
  output logic                       p1_rvalid,
  output logic [DataBitWidth-1:0]    p1_rdata,
  output logic                       busy,
  output logic [ColumnCount-1:0]     ram_we,
  output logic [AddressBitWidth-1:0] ram_addr,
  output logic [DataBitWidth-1:0]    ram_din,
  input  logic [DataBitWidth-1:0]    ram_dout
);

  logic                    run;
  logic [1:0]              req;
  logic [1:0]              grant;
  logic                    last_grant_q, last_grant_d;
  logic                    p0_rvalid_q, p0_rvalid_d;
  logic                    p1_rvalid_q, p1_rvalid_d;
  logic [DataBitWidth-1:0] p0_rdata_q, p0_rdata_d;
  logic [DataBitWidth-1:0] p1_rdata_q, p1_rdata_d;

`ifdef BRAM_ARB_CLEAR_EN
  localparam logic [AddressBitWidth-1:0] AddrOne = 1;

  state_e                     state_q, state_d;
  logic [AddressBitWidth-1:0] clr_q, clr_d;
  logic                       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    if (state_q == StateInit) begin
      clr_d = clr_q + AddrOne;
      if (clr_q == '1) begin
        state_d = StateRun;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StateInit;
      clr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
    end
  end

  assign run  = ~rst & (state_q == StateRun);
  assign busy = busy_q;
`else
  assign run  = ~rst;
  assign busy = 1'b0;
`endif

  // Requests are masked while in reset so nothing reaches the RAM or the ready lines.
  assign req = {p1_req, p0_req} & {2{run}};

  bram_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (grant[1]) begin
      ram_we   = p1_we;
      ram_addr = p1_addr;
      ram_din  = p1_wdata;
    end else if (grant[0]) begin
      ram_addr = p0_addr;
    end
`ifdef BRAM_ARB_CLEAR_EN
    if (~rst && state_q == StateInit) begin
      ram_we   = '1;
      ram_addr = clr_q;
      ram_din  = '0;
    end
`endif
  end

  // ram_dout reflects the pre-write word, so port 1 writes return the old contents.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[1]) begin
      last_grant_d = GrantP1;
    end else if (grant[0]) begin
      last_grant_d = GrantP0;
    end
    p0_rvalid_d = grant[0];
    p1_rvalid_d = grant[1];
    p0_rdata_d  = grant[0] ? ram_dout : p0_rdata_q;
    p1_rdata_d  = grant[1] ? ram_dout : p1_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GrantP1;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign p0_ready  = grant[0];
  assign p1_ready  = grant[1];
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
